// File: rtl/ca_pipe_pkg.sv
// Shared constants for the EX/MEM/WB pipeline slice: datapath defaults and
// the encodings of the EX operand-mux forwarding selects.
package ca_pipe_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  // Operand-mux selects: register file, MEM/WB writeback, EX/MEM ALU result
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : ca_pipe_pkg

// File: rtl/pipe_reg.sv
// Generic pipeline stage register with hold (en) and bubble insert (clr).
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled; clr loads an all-zero bubble instead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule : pipe_reg

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers, data-memory and writeback drive,
// and forwarding-select generation for the EX operand muxes.
module ex_mem_wb_pipe
  import ca_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [XLEN-1:0]   ex_alu_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [XLEN-1:0]   mem_alu_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_regwrite_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              hazard_o
);

  localparam int unsigned EXW = REG_AW + 3 + 2 * XLEN;
  localparam int unsigned WBW = REG_AW + 2 + 2 * XLEN;

  logic [EXW-1:0]    exmem_d, exmem_q;
  logic [WBW-1:0]    memwb_d, memwb_q;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              wb_memtoreg;
  logic [XLEN-1:0]   wb_alu;
  logic [XLEN-1:0]   wb_rdata;
  logic              stage_en;
  logic              exmem_clr;
  logic              mem_fwd_ok;
  logic              wb_fwd_ok;
  logic              load_pend;

  assign stage_en  = ~stall_i;
  // Flush while stalled is ignored so the held instruction is not lost
  assign exmem_clr = flush_i & ~stall_i;

  assign exmem_d = {ex_rd_i, ex_regwrite_i, ex_memread_i, ex_memwrite_i,
                    ex_alu_i, ex_store_data_i};

  pipe_reg #(.W(EXW)) u_exmem (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (stage_en),
    .clr   (exmem_clr),
    .d     (exmem_d),
    .q     (exmem_q)
  );

  assign {mem_rd, mem_regwrite, mem_memread, mem_memwrite,
          mem_alu_o, mem_wdata_o} = exmem_q;

  assign mem_re_o = mem_memread;
  assign mem_we_o = mem_memwrite;

  assign memwb_d = {mem_rd, mem_regwrite, mem_memread, mem_alu_o, mem_rdata_i};

  pipe_reg #(.W(WBW)) u_memwb (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (stage_en),
    .clr   (1'b0),
    .d     (memwb_d),
    .q     (memwb_q)
  );

  assign {wb_rd_o, wb_regwrite_o, wb_memtoreg, wb_alu, wb_rdata} = memwb_q;

  assign wb_data_o = wb_memtoreg ? wb_rdata : wb_alu;

  // A load in EX/MEM has no result yet, so it is excluded from MEM forwarding
  assign mem_fwd_ok = mem_regwrite & (mem_rd != '0) & ~mem_memread;
  assign wb_fwd_ok  = wb_regwrite_o & (wb_rd_o != '0);
  assign load_pend  = mem_regwrite & mem_memread & (mem_rd != '0);

  // Operand selects: youngest producer wins, x0 never matches a non-zero rd
  always_comb begin
    fwd_a_o = FWD_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs1_i)) begin
      fwd_a_o = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_o == ex_rs1_i)) begin
      fwd_a_o = FWD_WB;
    end

    fwd_b_o = FWD_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs2_i)) begin
      fwd_b_o = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_o == ex_rs2_i)) begin
      fwd_b_o = FWD_WB;
    end

    hazard_o = load_pend & ((mem_rd == ex_rs1_i) | (mem_rd == ex_rs2_i));
  end

endmodule : ex_mem_wb_pipe
